openflow_reg_ring_master: RTL and testbench

- Head of the register ring that links all OpenFlow switch instances on the FPGA; sits directly upstream of the first switch's ring register stage and receives the last stage's output.
- Accepts one host register request at a time and injects it onto the ring as a single-cycle valid.
- Collects the returning ack, or the unclaimed request, and hands a response with status back to the host.
- Enforces its own read/write completion timeouts and counts stray ring traffic.

---
 rtl/openflow_reg_ring_master.sv | 141 ++++++++++++++
 tb/tb_openflow_reg_ring_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/openflow_reg_ring_master.sv
// Register ring head: injects one host request per transaction onto the
// switch register ring and turns the returning ack/unclaimed pass into a response.
`ifndef SWITCH_REG_CTRL_WIDTH
`define SWITCH_REG_CTRL_WIDTH 32
`endif
`ifndef SWITCH_REG_CTRL_ID_POS
`define SWITCH_REG_CTRL_ID_POS 24
`endif
`ifndef SWITCH_REG_CTRL_RD_WR_L_POS
`define SWITCH_REG_CTRL_RD_WR_L_POS 31
`endif
`ifndef SWITCH_REG_WRITE_BUS_WIDTH
`define SWITCH_REG_WRITE_BUS_WIDTH 32
`endif
`ifndef SWITCH_REG_READ_BUS_WIDTH
`define SWITCH_REG_READ_BUS_WIDTH 32
`endif

module openflow_reg_ring_master #(
  parameter int unsigned RD_TIMEOUT = 1023,
  parameter int unsigned WR_WAIT = 64,
  parameter logic [`SWITCH_REG_READ_BUS_WIDTH-1:0] TIMEOUT_RESULT = 'hdead_beef
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   host_req_vld,
  output logic                                   host_req_rdy,
  input  logic [`SWITCH_REG_CTRL_WIDTH-1:0]      host_req_ctrl,
  input  logic [`SWITCH_REG_WRITE_BUS_WIDTH-1:0] host_req_wr_data,
  output logic                                   host_rsp_vld,
  input  logic                                   host_rsp_rdy,
  output logic [`SWITCH_REG_READ_BUS_WIDTH-1:0]  host_rsp_rd_data,
  output logic [1:0]                             host_rsp_status,
  output logic [`SWITCH_REG_WRITE_BUS_WIDTH-1:0] ring_out_wr_data_bus,
  output logic [`SWITCH_REG_CTRL_WIDTH-1:0]      ring_out_ctrl,
  output logic                                   ring_out_vld,
  output logic [`SWITCH_REG_READ_BUS_WIDTH-1:0]  ring_out_rd_data_bus,
  output logic                                   ring_out_ack,
  input  logic [`SWITCH_REG_WRITE_BUS_WIDTH-1:0] ring_in_wr_data_bus,
  input  logic [`SWITCH_REG_CTRL_WIDTH-1:0]      ring_in_ctrl,
  input  logic                                   ring_in_vld,
  input  logic [`SWITCH_REG_READ_BUS_WIDTH-1:0]  ring_in_rd_data_bus,
  input  logic                                   ring_in_ack,
  output logic [15:0]                            stray_count
);

  localparam int CW = `SWITCH_REG_CTRL_WIDTH;
  localparam int WW = `SWITCH_REG_WRITE_BUS_WIDTH;
  localparam int RW = `SWITCH_REG_READ_BUS_WIDTH;

  localparam logic [1:0] ST_OK = 2'd0;
  localparam logic [1:0] ST_NO_TARGET = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    RESPOND
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] ctrl_q;
  logic [WW-1:0] wr_q;
  logic [15:0]   cnt_q;
  logic [RW-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]    rsp_st_q, rsp_st_d;
  logic [15:0]   stray_q;
  logic          is_rd;
  logic          stray_hit;

  assign is_rd = ctrl_q[`SWITCH_REG_CTRL_RD_WR_L_POS];
  assign stray_hit = (ring_in_vld | ring_in_ack) && (state_q != WAIT_RESP);

  always_comb begin
    state_d = state_q;
    rsp_data_d = rsp_data_q;
    rsp_st_d = rsp_st_q;
    unique case (state_q)
      IDLE: if (host_req_vld) state_d = ISSUE;
      ISSUE: state_d = WAIT_RESP;
      WAIT_RESP: begin
        // Ack beats an unclaimed pass and the counter expiring
        if (ring_in_ack) begin
          state_d = RESPOND;
          rsp_st_d = ST_OK;
          rsp_data_d = ring_in_rd_data_bus;
        end else if (ring_in_vld) begin
          state_d = RESPOND;
          rsp_st_d = ST_NO_TARGET;
          rsp_data_d = TIMEOUT_RESULT;
        end else if (cnt_q == 16'd0) begin
          state_d = RESPOND;
          rsp_st_d = is_rd ? ST_TIMEOUT : ST_OK;
          rsp_data_d = is_rd ? TIMEOUT_RESULT : '0;
        end
      end
      RESPOND: if (host_rsp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      rsp_data_q <= '0;
      rsp_st_q <= ST_OK;
      stray_q <= '0;
    end else begin
      state_q <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_st_q <= rsp_st_d;
      if (state_q == IDLE && host_req_vld) begin
        ctrl_q <= host_req_ctrl;
        wr_q <= host_req_wr_data;
      end
      if (state_q == ISSUE)
        cnt_q <= is_rd ? 16'(RD_TIMEOUT) : 16'(WR_WAIT);
      else if (state_q == WAIT_RESP && cnt_q != 16'd0)
        cnt_q <= cnt_q - 16'd1;
      if (stray_hit && stray_q != 16'hffff)
        stray_q <= stray_q + 16'd1;
    end
  end

  assign host_req_rdy = (state_q == IDLE);
  assign host_rsp_vld = (state_q == RESPOND);
  assign host_rsp_rd_data = rsp_data_q;
  assign host_rsp_status = rsp_st_q;
  assign ring_out_vld = (state_q == ISSUE);
  assign ring_out_ctrl = (state_q == ISSUE) ? ctrl_q : '0;
  assign ring_out_wr_data_bus = (state_q == ISSUE) ? wr_q : '0;
  assign ring_out_rd_data_bus = '0;
  assign ring_out_ack = 1'b0;
  assign stray_count = stray_q;

endmodule

// File: tb/tb_openflow_reg_ring_master.sv
// Directed bench for the register ring head: vector table plus
// hand-written backpressure/stray and mid-transaction reset sequences.
`ifndef SWITCH_REG_CTRL_WIDTH
`define SWITCH_REG_CTRL_WIDTH 32
`endif
`ifndef SWITCH_REG_CTRL_ID_POS
`define SWITCH_REG_CTRL_ID_POS 24
`endif
`ifndef SWITCH_REG_CTRL_RD_WR_L_POS
`define SWITCH_REG_CTRL_RD_WR_L_POS 31
`endif
`ifndef SWITCH_REG_WRITE_BUS_WIDTH
`define SWITCH_REG_WRITE_BUS_WIDTH 32
`endif
`ifndef SWITCH_REG_READ_BUS_WIDTH
`define SWITCH_REG_READ_BUS_WIDTH 32
`endif

module tb_openflow_reg_ring_master;
  localparam int CW = `SWITCH_REG_CTRL_WIDTH;
  localparam int WW = `SWITCH_REG_WRITE_BUS_WIDTH;
  localparam int RW = `SWITCH_REG_READ_BUS_WIDTH;

  logic clk = 0;
  logic reset;
  logic host_req_vld;
  logic host_req_rdy;
  logic [CW-1:0] host_req_ctrl;
  logic [WW-1:0] host_req_wr_data;
  logic host_rsp_vld;
  logic host_rsp_rdy;
  logic [RW-1:0] host_rsp_rd_data;
  logic [1:0] host_rsp_status;
  logic [WW-1:0] ring_out_wr_data_bus;
  logic [CW-1:0] ring_out_ctrl;
  logic ring_out_vld;
  logic [RW-1:0] ring_out_rd_data_bus;
  logic ring_out_ack;
  logic [WW-1:0] ring_in_wr_data_bus;
  logic [CW-1:0] ring_in_ctrl;
  logic ring_in_vld;
  logic [RW-1:0] ring_in_rd_data_bus;
  logic ring_in_ack;
  logic [15:0] stray_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  openflow_reg_ring_master #(
    .RD_TIMEOUT(8),
    .WR_WAIT(64),
    .TIMEOUT_RESULT('hdead_beef)
  ) dut (
    .clk(clk),
    .reset(reset),
    .host_req_vld(host_req_vld),
    .host_req_rdy(host_req_rdy),
    .host_req_ctrl(host_req_ctrl),
    .host_req_wr_data(host_req_wr_data),
    .host_rsp_vld(host_rsp_vld),
    .host_rsp_rdy(host_rsp_rdy),
    .host_rsp_rd_data(host_rsp_rd_data),
    .host_rsp_status(host_rsp_status),
    .ring_out_wr_data_bus(ring_out_wr_data_bus),
    .ring_out_ctrl(ring_out_ctrl),
    .ring_out_vld(ring_out_vld),
    .ring_out_rd_data_bus(ring_out_rd_data_bus),
    .ring_out_ack(ring_out_ack),
    .ring_in_wr_data_bus(ring_in_wr_data_bus),
    .ring_in_ctrl(ring_in_ctrl),
    .ring_in_vld(ring_in_vld),
    .ring_in_rd_data_bus(ring_in_rd_data_bus),
    .ring_in_ack(ring_in_ack),
    .stray_count(stray_count)
  );

  typedef struct {
    logic        rd;
    logic [3:0]  id;
    logic [31:0] wr;
    int          dly;
    logic        ack;
    logic        vld;
    logic [31:0] rdat;
    logic [1:0]  st;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk_ctrl(input logic rd,
                                            input logic [3:0] id);
    logic [CW-1:0] c;
    c = '0;
    c[`SWITCH_REG_CTRL_RD_WR_L_POS] = rd;
    c[`SWITCH_REG_CTRL_ID_POS +: 4] = id;
    c[7:0] = 8'h40 + {4'h0, id};
    return c;
  endfunction

  task automatic ring_clear();
    ring_in_vld = 0;
    ring_in_ack = 0;
    ring_in_ctrl = '0;
    ring_in_wr_data_bus = '0;
    ring_in_rd_data_bus = '0;
  endtask

  // Request, issue-cycle checks, then wait for the response (ring driven per v)
  task automatic issue(input vec_t v, input string nm);
    logic [CW-1:0] c;
    int extra;
    bit got;
    c = mk_ctrl(v.rd, v.id);
    @(negedge clk);
    chk({nm, " req_rdy"}, host_req_rdy, 1);
    host_req_vld = 1;
    host_req_ctrl = c;
    host_req_wr_data = v.wr;
    @(negedge clk);
    host_req_vld = 0;
    chk({nm, " issue vld"}, ring_out_vld, 1);
    chk({nm, " issue ctrl"}, ring_out_ctrl, c);
    chk({nm, " issue wr"}, ring_out_wr_data_bus, v.wr);
    chk({nm, " issue rd/ack"}, {ring_out_rd_data_bus, ring_out_ack}, 0);
    extra = 0;
    got = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      ring_clear();
      if (ring_out_vld) extra++;
      if (host_rsp_vld) begin
        got = 1;
        chk({nm, " latency"}, k, v.lat);
        break;
      end
      if (k == v.dly) begin
        ring_in_ack = v.ack;
        ring_in_vld = v.vld;
        ring_in_ctrl = c;
        ring_in_wr_data_bus = v.wr;
        ring_in_rd_data_bus = v.rdat;
      end
    end
    chk({nm, " rsp seen"}, got, 1);
    chk({nm, " extra vld"}, extra, 0);
    chk({nm, " status"}, host_rsp_status, v.st);
    chk({nm, " data"}, host_rsp_rd_data, v.exp);
    chk({nm, " req_rdy low"}, host_req_rdy, 0);
  endtask

  task automatic accept(input string nm);
    host_rsp_rdy = 1;
    @(negedge clk);
    host_rsp_rdy = 0;
    chk({nm, " rsp dropped"}, host_rsp_vld, 0);
    chk({nm, " back idle"}, host_req_rdy, 1);
  endtask

  initial begin
    vec_t bp;
    logic [RW-1:0] held_d;
    logic [1:0] held_s;
    int bad;
    bit seen;

    vt[0] = '{1, 4'd2, 32'h0, 4, 1, 0, 32'h1234_5678, 2'd0, 32'h1234_5678, 5};
    vt[1] = '{0, 4'd7, 32'hA0A0_0001, 3, 0, 1, 32'h0, 2'd1, 32'hdead_beef, 4};
    vt[2] = '{0, 4'd3, 32'h0000_BEEF, 0, 0, 0, 32'h0, 2'd0, 32'h0, 66};
    vt[3] = '{1, 4'd1, 32'h0, 9, 1, 0, 32'h55, 2'd0, 32'h55, 10};
    vt[4] = '{1, 4'd1, 32'h0, 0, 0, 0, 32'h0, 2'd2, 32'hdead_beef, 10};
    vt[5] = '{1, 4'd4, 32'h0, 1, 1, 0, 32'hdead_0000, 2'd0, 32'hdead_0000, 2};
    vt[6] = '{1, 4'd5, 32'h0, 2, 1, 1, 32'hA5A5, 2'd0, 32'hA5A5, 3};
    vt[7] = '{1, 4'd6, 32'h0, 5, 0, 1, 32'h777, 2'd1, 32'hdead_beef, 6};
    vt[8] = '{0, 4'd2, 32'h1111_2222, 3, 1, 0, 32'h0, 2'd0, 32'h0, 4};

    reset = 1;
    host_req_vld = 0;
    host_req_ctrl = '0;
    host_req_wr_data = '0;
    host_rsp_rdy = 0;
    ring_clear();
    repeat (3) @(negedge clk);
    chk("reset req_rdy", host_req_rdy, 1);
    chk("reset rsp_vld", host_rsp_vld, 0);
    chk("reset rsp data/status", {host_rsp_rd_data, host_rsp_status}, 0);
    chk("reset ring_out", {ring_out_vld, ring_out_ack, ring_out_ctrl,
        ring_out_wr_data_bus[15:0]}, 0);
    chk("reset stray", stray_count, 0);
    reset = 0;

    for (int i = 0; i < 9; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      issue(vt[i], nm);
      accept(nm);
      chk({nm, " stray"}, stray_count, 0);
    end

    // Backpressure: response held 10 cycles, two stray acks meanwhile
    bp = '{1, 4'd3, 32'h0, 2, 1, 0, 32'hBEEF, 2'd0, 32'hBEEF, 3};
    issue(bp, "bp");
    held_d = host_rsp_rd_data;
    held_s = host_rsp_status;
    bad = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      ring_clear();
      if (!host_rsp_vld || host_req_rdy) bad++;
      if (host_rsp_rd_data !== held_d || host_rsp_status !== held_s) bad++;
      if (i == 3 || i == 6) begin
        ring_in_ack = 1;
        ring_in_rd_data_bus = 32'hFFFF_FFFF;
      end
    end
    chk("bp stable", bad, 0);
    chk("bp data", host_rsp_rd_data, 32'hBEEF);
    chk("bp stray", stray_count, 2);
    accept("bp");

    // Reset during WAIT_RESP, then the late ack arrives
    @(negedge clk);
    host_req_vld = 1;
    host_req_ctrl = mk_ctrl(1, 4'd2);
    @(negedge clk);
    host_req_vld = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    ring_in_ack = 1;
    ring_in_rd_data_bus = 32'h1234;
    @(negedge clk);
    ring_clear();
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (host_rsp_vld) seen = 1;
      @(negedge clk);
    end
    chk("rst no rsp", seen, 0);
    chk("rst stray", stray_count, 1);
    chk("rst req_rdy", host_req_rdy, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
